instr_fetch_mem: RTL

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_mem.sv
// Instruction memory with power-up NOP clear, program-load port and a 1-cycle fetch pipe.
// Optional macro IMEM_FAULT_EN: misaligned or out-of-range fetches return a fault instead of data.
module instr_fetch_mem #(
  parameter int          DEPTH    = 1024,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_ready,
  input  logic                       stall,
  input  logic                       flush,
  output logic [31:0]                instr,
  output logic                       instr_valid,
  output logic                       fault,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [$clog2(DEPTH)-3:0]   ld_addr,
  input  logic [31:0]                ld_data,
  output logic                       init_done,
  output logic                       fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = AW - 2;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   clr_cnt, clr_nxt;
  logic            clr_we;
  logic [31:0]     mem [DEPTH/4];

  logic            fetch_fire, ld_fire, bad_addr;
  logic [AW-1:0]   byte_idx;
  logic [WW-1:0]   word_idx, word_nxt;
  logic [31:0]     w0, w1, rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    clr_we    = 1'b0;
    if (state == CLEAR) begin
      clr_we  = 1'b1;
      clr_nxt = clr_cnt + 1'b1;
      if (clr_cnt == {WW{1'b1}}) state_nxt = RUN;
    end
  end

  assign fsm_state = state;
  assign init_done = (state == RUN);

  // Both ports are valid/ready: a transfer happens on the rising edge where
  // valid & ready are both high. A load write blocks fetches in the same cycle,
  // so a fetch never races a write to the word it reads.
  assign ld_ready    = (state == RUN);
  assign fetch_ready = (state == RUN) && !ld_valid && !(stall && instr_valid);
  assign ld_fire     = ld_valid && ld_ready;
  assign fetch_fire  = fetch_req && fetch_ready;

  always_ff @(posedge clk) begin
    if (clr_we)       mem[clr_cnt] <= NOP_WORD;
    else if (ld_fire) mem[ld_addr] <= ld_data;
  end

  // Read the addressed word and its successor; the successor index wraps so
  // a fetch near the top of memory picks up bytes from word 0.
  assign byte_idx = fetch_addr[AW-1:0];
  assign word_idx = byte_idx[AW-1:2];
  assign word_nxt = word_idx + 1'b1;
  assign w0       = mem[word_idx];
  assign w1       = mem[word_nxt];

  always_comb begin
    rd_word = w0;
    case (byte_idx[1:0])
      2'd1:    rd_word = {w0[23:0], w1[31:24]};
      2'd2:    rd_word = {w0[15:0], w1[31:16]};
      2'd3:    rd_word = {w0[7:0],  w1[31:8]};
      default: rd_word = w0;
    endcase
  end

`ifdef IMEM_FAULT_EN
  assign bad_addr = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= ADDR_W'(DEPTH));
`else
  logic unused_hi;
  assign unused_hi = ^fetch_addr[ADDR_W-1:AW];
  assign bad_addr  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else if (flush) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else if (stall && instr_valid) begin
      instr       <= instr;
      instr_valid <= instr_valid;
      fault       <= fault;
    end else if (fetch_fire) begin
      instr_valid <= 1'b1;
      instr       <= bad_addr ? NOP_WORD : rd_word;
      fault       <= bad_addr;
    end else begin
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end
  end

endmodule
